regfile_dump: RTL and testbench

//   Debug/trace reader for the 32x32 CPU register file. A start pulse walks

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/regfile_dump.sv | 154 +++++++++++++++
 tb/tb_regfile_dump.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file parameters, regdump FSM encodings and the trace beat payload.
package regfile_pkg;

   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned REGDUMP_ST_W = 3;

   typedef logic [REGDUMP_ST_W-1:0] regdump_state_t;

   localparam regdump_state_t REGDUMP_IDLE  = 3'd0;
   localparam regdump_state_t REGDUMP_FETCH = 3'd1;
   localparam regdump_state_t REGDUMP_SEND  = 3'd2;
   localparam regdump_state_t REGDUMP_CSUM  = 3'd3;
   localparam regdump_state_t REGDUMP_DONE  = 3'd4;

   localparam logic [ADDR_W-1:0] REGDUMP_LAST_IDX = ADDR_W'(NUM_REGS - 1);

   // One streamed beat: register value (or checksum) plus its side-band flags.
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] index;
      logic              last;
      logic              csum;
   } regdump_beat_t;

endpackage

// File: rtl/regfile_dump.sv
// Debug/trace reader: walks the register file through a spare read port and streams
// each value on valid/ready. Define REGDUMP_CHECKSUM_EN to append an XOR checksum beat.
module regfile_dump
   import regfile_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic [ADDR_W-1:0] m_index,
   output logic              m_last,
   output logic              m_csum
);

`ifdef REGDUMP_CHECKSUM_EN
   localparam bit HAS_CSUM = 1'b1;
`else
   localparam bit HAS_CSUM = 1'b0;
`endif

   regdump_state_t    state,   state_nxt;
   logic [ADDR_W-1:0] idx,     idx_nxt;
   regdump_beat_t     beat,    beat_nxt;
   logic              valid_q, valid_nxt;
   logic              busy_q,  busy_nxt;
   logic              done_q,  done_nxt;
`ifdef REGDUMP_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q,  csum_nxt;
`endif

   // Next-state and next-output logic
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      beat_nxt  = beat;
      valid_nxt = valid_q;
`ifdef REGDUMP_CHECKSUM_EN
      csum_nxt  = csum_q;
`endif

      case (state)
         REGDUMP_IDLE: begin
            if (start) begin
               idx_nxt   = '0;
`ifdef REGDUMP_CHECKSUM_EN
               csum_nxt  = '0;
`endif
               state_nxt = REGDUMP_FETCH;
            end
         end

         REGDUMP_FETCH: begin
            beat_nxt.data  = rd_data;
            beat_nxt.index = idx;
            beat_nxt.last  = (idx == REGDUMP_LAST_IDX) && !HAS_CSUM;
            beat_nxt.csum  = 1'b0;
            valid_nxt      = 1'b1;
            state_nxt      = REGDUMP_SEND;
         end

         REGDUMP_SEND: begin
            if (m_ready) begin
               valid_nxt = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
               csum_nxt  = csum_q ^ beat.data;
`endif
               if (idx == REGDUMP_LAST_IDX) begin
`ifdef REGDUMP_CHECKSUM_EN
                  state_nxt = REGDUMP_CSUM;
`else
                  state_nxt = REGDUMP_DONE;
`endif
               end else begin
                  idx_nxt   = idx + ADDR_W'(1);
                  state_nxt = REGDUMP_FETCH;
               end
            end
         end

`ifdef REGDUMP_CHECKSUM_EN
         // First cycle loads the checksum beat; it then holds until accepted.
         REGDUMP_CSUM: begin
            if (!valid_q) begin
               beat_nxt.data  = csum_q;
               beat_nxt.index = REGDUMP_LAST_IDX;
               beat_nxt.last  = 1'b1;
               beat_nxt.csum  = 1'b1;
               valid_nxt      = 1'b1;
            end else if (m_ready) begin
               valid_nxt = 1'b0;
               state_nxt = REGDUMP_DONE;
            end
         end
`endif

         REGDUMP_DONE: begin
            state_nxt = REGDUMP_IDLE;
         end

         default: begin
            state_nxt = REGDUMP_IDLE;
         end
      endcase

      busy_nxt = (state_nxt == REGDUMP_FETCH) || (state_nxt == REGDUMP_SEND) ||
                 (state_nxt == REGDUMP_CSUM);
      done_nxt = (state_nxt == REGDUMP_DONE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= REGDUMP_IDLE;
         idx     <= '0;
         beat    <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         idx     <= idx_nxt;
         beat    <= beat_nxt;
         valid_q <= valid_nxt;
         busy_q  <= busy_nxt;
         done_q  <= done_nxt;
      end
   end

`ifdef REGDUMP_CHECKSUM_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         csum_q <= '0;
      end else begin
         csum_q <= csum_nxt;
      end
   end
`endif

   assign busy    = busy_q;
   assign done    = done_q;
   assign rd_addr = idx;
   assign m_valid = valid_q;
   assign m_data  = beat.data;
   assign m_index = beat.index;
   assign m_last  = beat.last;
   assign m_csum  = beat.csum;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: register-file model, scenario table and reset/restart sequence.
module tb_regfile_dump;
   import regfile_pkg::*;

`ifdef REGDUMP_CHECKSUM_EN
   localparam bit HAS_CSUM = 1'b1;
`else
   localparam bit HAS_CSUM = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic [ADDR_W-1:0] m_index;
   logic              m_last;
   logic              m_csum;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] exp_vals [NUM_REGS];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   regfile_dump dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_index (m_index),
      .m_last  (m_last),
      .m_csum  (m_csum)
   );

   // Register file model: write at the clock edge, combinational read, reg0 reads 0
   always @(posedge clk) begin
      if (wr_en && wr_addr != '0) regs[wr_addr] <= wr_data;
   end
   assign rd_data = (rd_addr == '0) ? '0 : regs[rd_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic preload();
      for (int k = 1; k < int'(NUM_REGS); k++) begin
         wr_en   = 1'b1;
         wr_addr = ADDR_W'(k);
         wr_data = 32'(k) * 32'h0101_0101;
         @(negedge clk);
      end
      wr_en = 1'b0;
   endtask

   // One complete dump checked beat by beat against exp_vals
   task automatic run_dump(input int rmod, input bit glitch, input bit wr_mode);
      int          beat;
      int          cyc;
      int          nbeats;
      bit          hs_prev;
      bit          rdy;
      bit          w5;
      bit          w2;
      logic [31:0] csum_m;
      logic [31:0] exp_d;
      logic [31:0] exp_i;
      logic        exp_last;
      logic        exp_c;

      nbeats = int'(NUM_REGS) + (HAS_CSUM ? 1 : 0);
      csum_m = '0;
      for (int k = 0; k < int'(NUM_REGS); k++) csum_m ^= exp_vals[k];
      beat = 0; cyc = 0; hs_prev = 0; w5 = 0; w2 = 0;

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      check("valid_in_first_fetch", 32'(m_valid), 32'd0);

      while (beat < nbeats && cyc < 3000) begin
         @(negedge clk);
         wr_en = 1'b0;
         start = 1'b0;
         if (cyc == 0) check("first_valid_latency", 32'(m_valid), 32'd1);
         if (hs_prev) check("valid_drop_after_hs", 32'(m_valid), 32'd0);
         check("busy_in_dump", 32'(busy), 32'd1);
         check("done_in_dump", 32'(done), 32'd0);
         if (m_valid) begin
            if (beat < int'(NUM_REGS)) begin
               exp_d    = exp_vals[beat];
               exp_i    = 32'(beat);
               exp_last = (beat == int'(NUM_REGS) - 1) && !HAS_CSUM;
               exp_c    = 1'b0;
            end else begin
               exp_d    = csum_m;
               exp_i    = 32'(NUM_REGS - 1);
               exp_last = 1'b1;
               exp_c    = 1'b1;
            end
            check("m_data", m_data, exp_d);
            check("m_index", 32'(m_index), exp_i);
            check("m_last", 32'(m_last), 32'(exp_last));
            check("m_csum", 32'(m_csum), 32'(exp_c));
         end
         rdy     = (rmod <= 1) || ((cyc % rmod) == rmod - 1);
         m_ready = rdy;
         hs_prev = m_valid && rdy;
         if (hs_prev) beat++;
         if (glitch && !hs_prev && (cyc % 5 == 2)) start = 1'b1;
         if (wr_mode && beat == 1 && !w5) begin
            wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; w5 = 1;
         end
         if (wr_mode && beat == 3 && !w2) begin
            wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h1234_5678; w2 = 1;
         end
         cyc++;
      end
      check("beats_accepted", 32'(beat), 32'(nbeats));

      @(negedge clk);
      m_ready = 1'b0;
      wr_en   = 1'b0;
      check("done_pulse", 32'(done), 32'd1);
      check("busy_in_done", 32'(busy), 32'd0);
      check("valid_in_done", 32'(m_valid), 32'd0);
      if (glitch) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("done_one_cycle", 32'(done), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_busy", 32'(busy), 32'd0);
         check("idle_valid", 32'(m_valid), 32'd0);
      end
   endtask

   typedef struct {
      int          rmod;
      bit          glitch;
      bit          wr_mode;
      logic [31:0] exp2;
      logic [31:0] exp5;
   } vec_t;

   vec_t vecs [3];
   int   cnt;

   initial begin
      vecs[0] = '{rmod: 1, glitch: 1'b0, wr_mode: 1'b0, exp2: 32'h0202_0202, exp5: 32'h0505_0505};
      vecs[1] = '{rmod: 3, glitch: 1'b1, wr_mode: 1'b0, exp2: 32'h0202_0202, exp5: 32'h0505_0505};
      vecs[2] = '{rmod: 2, glitch: 1'b0, wr_mode: 1'b1, exp2: 32'h0202_0202, exp5: 32'hDEAD_BEEF};

      reset_n = 1'b0; start = 1'b0; m_ready = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_valid", 32'(m_valid), 32'd0);
      check("rst_data", m_data, 32'd0);
      check("rst_index", 32'(m_index), 32'd0);
      check("rst_last", 32'(m_last), 32'd0);
      check("rst_csum", 32'(m_csum), 32'd0);
      check("rst_rd_addr", 32'(rd_addr), 32'd0);
      reset_n = 1'b1;

      for (int v = 0; v < 3; v++) begin
         preload();
         for (int k = 0; k < int'(NUM_REGS); k++) exp_vals[k] = 32'(k) * 32'h0101_0101;
         exp_vals[2] = vecs[v].exp2;
         exp_vals[5] = vecs[v].exp5;
         run_dump(vecs[v].rmod, vecs[v].glitch, vecs[v].wr_mode);
      end

      // Reset while beat 10 is stalled, then a fresh dump from index 0
      preload();
      for (int k = 0; k < int'(NUM_REGS); k++) exp_vals[k] = 32'(k) * 32'h0101_0101;
      start = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      m_ready = 1'b1;
      cnt     = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!(m_valid && m_index == 5'd10) && cnt < 200);
      m_ready = 1'b0;
      check("reached_beat10", 32'(m_index), 32'd10);
      repeat (2) @(negedge clk);
      check("stall_valid", 32'(m_valid), 32'd1);
      check("stall_index", 32'(m_index), 32'd10);
      check("stall_data", m_data, 32'h0A0A_0A0A);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(m_valid), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_done", 32'(done), 32'd0);
      check("async_rst_rd_addr", 32'(rd_addr), 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_hold_done", 32'(done), 32'd0);
      end
      reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_idle_busy", 32'(busy), 32'd0);
      check("post_rst_no_done", 32'(done), 32'd0);
      run_dump(1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
